// File: rtl/ram_save_acc.sv
// ram_save_acc
//   Result buffer for the GEMM output path. One write port that either
//   overwrites or accumulates (signed, optional saturation) through a
//   two-stage read-modify-write pipeline, one read port with 1 or 2 cycles
//   of latency, and a sequencer that zeroes the whole array on request.
//
// Ports
//   clka       clock, rising edge
//   rsta       synchronous active-high reset (memory contents are kept)
//   clr_start  pulse: zero all DEPTH words
//   clr_busy   high while the clear sequence runs
//   wr_en      write request, accepted when wr_en & wr_ready
//   wr_acc     1: mem[addr] += wr_data, 0: mem[addr] = wr_data
//   wr_addr    write address
//   wr_data    write / accumulate operand
//   wr_ready   ~clr_busy
//   rd_en      read request, accepted when rd_en & rd_ready
//   rd_addr    read address
//   rd_ready   ~clr_busy
//   rd_data    read data, held between reads
//   rd_valid   one-cycle pulse RD_LAT cycles after an accepted read
//   ovf        sticky: an accumulate saturated (SAT=1) or wrapped (SAT=0)
module ram_save_acc #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1,
    parameter int SAT    = 1
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              clr_start,
    output logic              clr_busy,
    input  logic              wr_en,
    input  logic              wr_acc,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              ovf
);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_caddr;
    logic [ADDR_W-1:0] w_caddr_nxt;
    logic              w_clr_we;
    logic              w_clr_go;

    logic              r_s1_valid;
    logic              r_s1_acc;
    logic [ADDR_W-1:0] r_s1_addr;
    logic [DATA_W-1:0] r_s1_data;
    logic [DATA_W-1:0] r_s1_old;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_s1_new;
    logic              w_s1_ovf;

    logic              w_wr_go;
    logic              w_rd_go;
    logic              w_wr_fwd;
    logic              w_rd_fwd;
    logic [DATA_W-1:0] w_rd_val;

    logic              r_rd_v1;
    logic [DATA_W-1:0] r_rd_d1;
    logic              r_ovf;

    assign clr_busy = (r_state == ST_CLEAR);
    assign wr_ready = ~clr_busy;
    assign rd_ready = ~clr_busy;
    assign ovf      = r_ovf;

    assign w_wr_go  = wr_en & wr_ready;
    assign w_rd_go  = rd_en & rd_ready;

    // The word retiring from S1 this edge is not yet in memory, so both the
    // RMW operand fetch and the read port take it from S1 on an address hit.
    assign w_wr_fwd = r_s1_valid && (r_s1_addr == wr_addr);
    assign w_rd_fwd = r_s1_valid && (r_s1_addr == rd_addr);
    assign w_rd_val = w_rd_fwd ? w_s1_new : r_mem[rd_addr];

    // S1 arithmetic: one extra bit of sum; overflow when the top two bits differ.
    always_comb begin
        w_sum    = {r_s1_old[DATA_W-1], r_s1_old} + {r_s1_data[DATA_W-1], r_s1_data};
        w_s1_ovf = r_s1_acc && (w_sum[DATA_W] != w_sum[DATA_W-1]);
        if (!r_s1_acc) begin
            w_s1_new = r_s1_data;
        end else if (w_s1_ovf && (SAT != 0)) begin
            w_s1_new = w_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                     : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            w_s1_new = w_sum[DATA_W-1:0];
        end
    end

    // Clear sequencer next-state. A write still in S1 owns the single memory
    // write port, so zeroing holds off for that one drain cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_caddr_nxt = r_caddr;
        w_clr_we    = 1'b0;
        w_clr_go    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clr_start) begin
                    w_clr_go    = 1'b1;
                    w_state_nxt = ST_CLEAR;
                    w_caddr_nxt = '0;
                end
            end
            ST_CLEAR: begin
                if (!r_s1_valid) begin
                    w_clr_we    = 1'b1;
                    w_caddr_nxt = r_caddr + 1'b1;
                    if (r_caddr == ADDR_W'(DEPTH - 1)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            r_state <= ST_IDLE;
            r_caddr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_caddr <= w_caddr_nxt;
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            r_s1_valid <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_s1_valid <= w_wr_go;
            r_ovf      <= (r_ovf & ~w_clr_go) | (r_s1_valid & w_s1_ovf);
        end
    end

    always_ff @(posedge clka) begin
        if (w_wr_go) begin
            r_s1_acc  <= wr_acc;
            r_s1_addr <= wr_addr;
            r_s1_data <= wr_data;
            r_s1_old  <= w_wr_fwd ? w_s1_new : r_mem[wr_addr];
        end
    end

    // Memory port: S1 retire has priority over clear; reset drops both.
    always_ff @(posedge clka) begin
        if (!rsta) begin
            if (r_s1_valid) begin
                r_mem[r_s1_addr] <= w_s1_new;
            end else if (w_clr_we) begin
                r_mem[r_caddr] <= '0;
            end
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            r_rd_v1 <= 1'b0;
            r_rd_d1 <= '0;
        end else begin
            r_rd_v1 <= w_rd_go;
            if (w_rd_go) begin
                r_rd_d1 <= w_rd_val;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              r_rd_v2;
            logic [DATA_W-1:0] r_rd_d2;

            always_ff @(posedge clka) begin
                if (rsta) begin
                    r_rd_v2 <= 1'b0;
                    r_rd_d2 <= '0;
                end else begin
                    r_rd_v2 <= r_rd_v1;
                    if (r_rd_v1) begin
                        r_rd_d2 <= r_rd_d1;
                    end
                end
            end

            assign rd_valid = r_rd_v2;
            assign rd_data  = r_rd_d2;
        end else begin : g_lat1
            assign rd_valid = r_rd_v1;
            assign rd_data  = r_rd_d1;
        end
    endgenerate

endmodule

// File: tb/tb_ram_save_acc.sv
// tb_ram_save_acc
//   Drives two instances with identical stimulus: A (RD_LAT=1, saturating)
//   and B (RD_LAT=2, wrapping). A behavioural model applies every accepted
//   write in acceptance order to a plain array, so a read accepted in a cycle
//   sees all earlier writes and none from its own cycle.
module tb_ram_save_acc;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 200;

    logic          clka = 1'b0;
    logic          rsta;
    logic          clr_start;
    logic          wr_en;
    logic          wr_acc;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    logic          a_clr_busy, a_wr_ready, a_rd_ready, a_rd_valid, a_ovf;
    logic [DW-1:0] a_rd_data;
    logic          b_clr_busy, b_wr_ready, b_rd_ready, b_rd_valid, b_ovf;
    logic [DW-1:0] b_rd_data;

    always #5 clka = ~clka;

    ram_save_acc #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(1), .SAT(1)) u_a (
        .clka(clka), .rsta(rsta), .clr_start(clr_start), .clr_busy(a_clr_busy),
        .wr_en(wr_en), .wr_acc(wr_acc), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(a_wr_ready), .rd_en(rd_en), .rd_addr(rd_addr), .rd_ready(a_rd_ready),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .ovf(a_ovf)
    );

    ram_save_acc #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(2), .SAT(0)) u_b (
        .clka(clka), .rsta(rsta), .clr_start(clr_start), .clr_busy(b_clr_busy),
        .wr_en(wr_en), .wr_acc(wr_acc), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(b_wr_ready), .rd_en(rd_en), .rd_addr(rd_addr), .rd_ready(b_rd_ready),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .ovf(b_ovf)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference state: s = saturating image, w = wrapping image.
    logic [DW-1:0] m_s [DEPTH];
    logic [DW-1:0] m_w [DEPTH];
    bit            m_ovf_s, m_ovf_w, m_pend_s, m_pend_w;
    int            m_busy, m_drain, m_caddr;
    logic [DW-1:0] m_rd_a, m_rd_b;
    bit            e_va, e_vb;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } rd_t;
    rd_t qb[$];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    endtask

    function automatic logic [DW-1:0] acc_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input bit sat, output bit o);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        if (o && sat) return (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        return s[31:0];
    endfunction

    task automatic idle_in();
        rsta = 1'b0; clr_start = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    // One clock: update the model from the inputs present at the edge,
    // then compare every output on the following falling edge.
    task automatic step();
        bit            wacc, racc, go, o;
        logic [DW-1:0] ra_s, ra_w;
        wacc = wr_en && (m_busy == 0) && !rsta;
        racc = rd_en && (m_busy == 0) && !rsta;
        go   = clr_start && (m_busy == 0) && !rsta;
        @(posedge clka);
        cyc++;
        e_va = 1'b0;
        e_vb = 1'b0;
        if (rsta) begin
            m_busy = 0; m_drain = 0;
            m_ovf_s = 0; m_ovf_w = 0; m_pend_s = 0; m_pend_w = 0;
            m_rd_a = '0; m_rd_b = '0;
            qb.delete();
        end else begin
            m_ovf_s  = (m_ovf_s & ~go) | m_pend_s;
            m_ovf_w  = (m_ovf_w & ~go) | m_pend_w;
            m_pend_s = 0;
            m_pend_w = 0;
            if (m_busy > 0) begin
                if (m_drain != 0) m_drain = 0;
                else begin
                    m_s[m_caddr] = '0;
                    m_w[m_caddr] = '0;
                    m_caddr++;
                end
                m_busy--;
            end
            if (racc) begin
                ra_s   = m_s[rd_addr];
                ra_w   = m_w[rd_addr];
                e_va   = 1'b1;
                m_rd_a = ra_s;
                qb.push_back('{due: cyc + 1, d: ra_w});
            end
            if (wacc) begin
                if (wr_acc) begin
                    m_s[wr_addr] = acc_ref(m_s[wr_addr], wr_data, 1'b1, o); m_pend_s = o;
                    m_w[wr_addr] = acc_ref(m_w[wr_addr], wr_data, 1'b0, o); m_pend_w = o;
                end else begin
                    m_s[wr_addr] = wr_data;
                    m_w[wr_addr] = wr_data;
                end
            end
            if (go) begin
                m_busy  = DEPTH + int'(wacc);
                m_drain = int'(wacc);
                m_caddr = 0;
            end
            if (qb.size() > 0 && qb[0].due == cyc) begin
                e_vb   = 1'b1;
                m_rd_b = qb.pop_front().d;
            end
        end
        @(negedge clka);
        check("a_rd_valid", 32'(a_rd_valid), 32'(e_va));
        check("a_rd_data",  a_rd_data, m_rd_a);
        check("b_rd_valid", 32'(b_rd_valid), 32'(e_vb));
        check("b_rd_data",  b_rd_data, m_rd_b);
        check("a_ovf",      32'(a_ovf), 32'(m_ovf_s));
        check("b_ovf",      32'(b_ovf), 32'(m_ovf_w));
        check("a_clr_busy", 32'(a_clr_busy), 32'(m_busy != 0));
        check("b_clr_busy", 32'(b_clr_busy), 32'(m_busy != 0));
        check("a_wr_ready", 32'(a_wr_ready), 32'(m_busy == 0));
        check("a_rd_ready", 32'(a_rd_ready), 32'(m_busy == 0));
        check("b_wr_ready", 32'(b_wr_ready), 32'(m_busy == 0));
        check("b_rd_ready", 32'(b_rd_ready), 32'(m_busy == 0));
    endtask

    task automatic do_wr(input int a, input logic [DW-1:0] d, input bit acc);
        wr_en = 1'b1; wr_acc = acc; wr_addr = AW'(a); wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_rd(input int a);
        rd_en = 1'b1; rd_addr = AW'(a);
        step();
        rd_en = 1'b0;
    endtask

    // Pulse clr_start (optionally with a same-cycle write), throw dropped
    // requests at the busy DUTs, and count the busy cycles seen.
    task automatic do_clear(input bit with_wr, input string tag);
        int n_busy;
        clr_start = 1'b1;
        if (with_wr) begin
            wr_en = 1'b1; wr_acc = 1'b0; wr_addr = AW'(20); wr_data = 32'h0000_1234;
        end
        step();
        n_busy = int'(a_clr_busy);
        idle_in();
        for (int k = 0; k < DEPTH + 4; k++) begin
            if (m_busy > 0) begin
                wr_en = 1'b1; wr_acc = 1'b0; wr_addr = AW'(k % 8); wr_data = 32'hDEAD_0000 + 32'(k);
                rd_en = 1'b1; rd_addr = AW'(k % 8);
                clr_start = 1'b1;
            end else begin
                idle_in();
            end
            step();
            n_busy += int'(a_clr_busy);
        end
        idle_in();
        check(tag, 32'(n_busy), 32'(DEPTH + int'(with_wr)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_s[i] = '0; m_w[i] = '0;
        end
        m_rd_a = '0; m_rd_b = '0; m_busy = 0; m_drain = 0; m_caddr = 0;
        idle_in();
        wr_acc = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;

        // Reset held two cycles.
        rsta = 1'b1;
        step();
        step();
        rsta = 1'b0;
        check("rst_ovf",   32'(a_ovf), 32'd0);
        check("rst_ready", 32'(a_wr_ready & a_rd_ready & b_wr_ready & b_rd_ready), 32'd1);

        // Bring memory to a known all-zero state.
        do_clear(1'b0, "init_busy_cycles");

        // Overwrite then forwarded read.
        do_wr(3, 32'h5, 1'b0);
        do_rd(3);
        check("t2_a_data", a_rd_data, 32'h5);
        step();
        check("t2_b_data", b_rd_data, 32'h5);

        // Back-to-back accumulate.
        do_wr(7, 32'd10, 1'b0);
        do_wr(7, 32'd1, 1'b1);
        do_wr(7, 32'd2, 1'b1);
        do_wr(7, 32'd3, 1'b1);
        do_rd(7);
        check("t3_a_data", a_rd_data, 32'd16);
        step();
        check("t3_b_data", b_rd_data, 32'd16);

        // Saturate (A) vs wrap (B).
        do_wr(9, 32'h7FFF_FFF0, 1'b0);
        do_wr(9, 32'h0000_0100, 1'b1);
        do_rd(9);
        check("t4_a_sat", a_rd_data, 32'h7FFF_FFFF);
        check("t4_a_ovf", 32'(a_ovf), 32'd1);
        step();
        check("t4_b_wrap", b_rd_data, 32'h8000_00F0);
        check("t4_b_ovf",  32'(b_ovf), 32'd1);

        // Clear with a write landing on the start cycle (one drain cycle).
        for (int i = 0; i < 8; i++) do_wr(i, 32'h100 + 32'(i), 1'b0);
        step();
        do_clear(1'b1, "t5_busy_cycles");
        check("t5_ovf", 32'(a_ovf | b_ovf), 32'd0);
        for (int i = 0; i < 8; i++) begin
            do_rd(i);
            check("t5_zero", a_rd_data, 32'd0);
        end
        do_rd(20);
        check("t5_zero20", a_rd_data, 32'd0);

        // Reset while the clear is at caddr 100.
        for (int i = 96; i <= 104; i++) do_wr(i, 32'h1000 + 32'(i), 1'b0);
        step();
        step();
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        for (int k = 0; k < 100; k++) step();
        rsta = 1'b1;
        step();
        rsta = 1'b0;
        check("t6_busy_drop", 32'(a_clr_busy | b_clr_busy), 32'd0);
        for (int i = 96; i <= 104; i++) begin
            do_rd(i);
            if (i == 99)  check("t6_word99",  a_rd_data, 32'd0);
            if (i == 100) check("t6_word100", a_rd_data, 32'h1064);
        end
        step();

        // Randomized traffic over a small address window.
        for (int i = 0; i < 600; i++) begin
            wr_en   = ($urandom_range(9) < 6);
            wr_acc  = 1'($urandom_range(1));
            wr_addr = AW'($urandom_range(15));
            case ($urandom_range(3))
                0: wr_data = $urandom;
                1: wr_data = 32'($urandom_range(200)) - 32'd100;
                2: wr_data = 32'h7FFF_FF00 + 32'($urandom_range(255));
                default: wr_data = 32'h8000_0000 + 32'($urandom_range(255));
            endcase
            rd_en   = 1'($urandom_range(1));
            rd_addr = AW'($urandom_range(15));
            step();
        end
        idle_in();
        step();
        step();
        for (int i = 0; i < 16; i++) do_rd(i);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
